// File: rtl/paddle_controller_pkg.sv
// Shared game geometry and paddle state encoding, used by the paddle,
// renderer and ball logic.
package paddle_controller_pkg;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int PADDLE_W  = 64;
  localparam int PADDLE_H  = 8;
  localparam int PADDLE_Y  = 440;
  localparam int SPEED_MIN = 2;
  localparam int SPEED_MAX = 8;

  localparam int COORD_W = 10;
  localparam int SPEED_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE_L = 2'd1,
    ST_MOVE_R = 2'd2
  } paddle_state_e;

endpackage

// File: rtl/paddle_controller_if.sv
// Button/vsync inputs and sprite position outputs of the paddle controller.
interface paddle_controller_if;
  import paddle_controller_pkg::*;

  logic               vsync;
  logic               enable;
  logic               btn_left;
  logic               btn_right;
  logic               recenter;
  logic [COORD_W-1:0] sprite_x;
  logic [COORD_W-1:0] sprite_y;
  logic               moving;
  logic               frame_tick;

  modport master (
    output vsync, enable, btn_left, btn_right, recenter,
    input  sprite_x, sprite_y, moving, frame_tick
  );

  modport slave (
    input  vsync, enable, btn_left, btn_right, recenter,
    output sprite_x, sprite_y, moving, frame_tick
  );

endinterface

// File: rtl/paddle_controller_sync_edge.sv
// Two-flop synchroniser with an optional registered falling-edge pulse.
module paddle_controller_sync_edge #(
  parameter logic RESET_VAL = 1'b0,
  parameter bit   EDGE      = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic fall
);

  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= RESET_VAL;
      s2 <= RESET_VAL;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  assign dout = s2;

  generate
    if (EDGE) begin : g_edge
      logic       s3;
      logic [1:0] fill;
      logic       pulse;

      // Edges are ignored until the pipeline holds only post-reset samples,
      // so an input already low at reset release never yields a pulse.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          s3    <= RESET_VAL;
          fill  <= '0;
          pulse <= 1'b0;
        end else begin
          s3 <= s2;
          if (fill != 2'd3) fill <= fill + 2'd1;
          pulse <= (fill == 2'd3) && s3 && !s2;
        end
      end

      assign fall = pulse;
    end else begin : g_level
      assign fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/paddle_controller.sv
// Per-frame paddle X position generator with accelerating, clamped movement,
// updated once per detected vsync falling edge.
module paddle_controller
  import paddle_controller_pkg::*;
#(
  parameter int SCREEN_W  = paddle_controller_pkg::SCREEN_W,
  parameter int PADDLE_W  = paddle_controller_pkg::PADDLE_W,
  parameter int PADDLE_Y  = paddle_controller_pkg::PADDLE_Y,
  parameter int SPEED_MIN = paddle_controller_pkg::SPEED_MIN,
  parameter int SPEED_MAX = paddle_controller_pkg::SPEED_MAX
) (
  input  logic               clk,
  input  logic               reset,
  paddle_controller_if.slave bus
);

  localparam logic [COORD_W:0]   MAX_X_W = (COORD_W+1)'(SCREEN_W - PADDLE_W);
  localparam logic [COORD_W-1:0] MAX_X   = COORD_W'(SCREEN_W - PADDLE_W);
  localparam logic [COORD_W-1:0] START_X = COORD_W'((SCREEN_W - PADDLE_W) / 2);
  localparam logic [COORD_W-1:0] POS_Y   = COORD_W'(PADDLE_Y);
  localparam logic [SPEED_W-1:0] SMIN    = SPEED_W'(SPEED_MIN);
  localparam logic [SPEED_W-1:0] SMAX    = SPEED_W'(SPEED_MAX);

  logic btn_l;
  logic btn_r;
  logic vs_sync;
  logic tick;
  logic unused_fall_l;
  logic unused_fall_r;
  logic unused_vs_sync;

  paddle_controller_sync_edge #(.RESET_VAL(1'b1), .EDGE(1'b1)) u_sync_vsync (
    .clk(clk), .reset(reset), .din(bus.vsync), .dout(vs_sync), .fall(tick)
  );
  paddle_controller_sync_edge #(.RESET_VAL(1'b0), .EDGE(1'b0)) u_sync_left (
    .clk(clk), .reset(reset), .din(bus.btn_left), .dout(btn_l), .fall(unused_fall_l)
  );
  paddle_controller_sync_edge #(.RESET_VAL(1'b0), .EDGE(1'b0)) u_sync_right (
    .clk(clk), .reset(reset), .din(bus.btn_right), .dout(btn_r), .fall(unused_fall_r)
  );

  assign unused_vs_sync = vs_sync;

  logic [COORD_W-1:0] pos_x;
  logic [COORD_W-1:0] pos_y;
  logic [SPEED_W-1:0] speed;
  paddle_state_e      state;
  logic               moving_q;
  logic               pend;

  logic               dir_l;
  logic               dir_r;
  paddle_state_e      tgt;
  logic [SPEED_W-1:0] step;
  logic [SPEED_W-1:0] next_speed;
  logic [COORD_W:0]   x_w;
  logic [COORD_W:0]   step_w;
  logic [COORD_W:0]   sum_w;
  logic [COORD_W-1:0] left_x;
  logic [COORD_W-1:0] right_x;

  always_comb begin
    dir_l      = btn_l && !btn_r;
    dir_r      = btn_r && !btn_l;
    tgt        = dir_l ? ST_MOVE_L : ST_MOVE_R;
    step       = SMIN;
    next_speed = SMIN + SPEED_W'(1);
    if (state == tgt) begin
      step       = speed;
      next_speed = (speed >= SMAX) ? SMAX : speed + SPEED_W'(1);
    end
    x_w     = {1'b0, pos_x};
    step_w  = (COORD_W+1)'(step);
    sum_w   = x_w + step_w;
    left_x  = (x_w < step_w) ? '0 : pos_x - COORD_W'(step);
    right_x = (sum_w > MAX_X_W) ? MAX_X : sum_w[COORD_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_x    <= START_X;
      pos_y    <= POS_Y;
      speed    <= SMIN;
      state    <= ST_IDLE;
      moving_q <= 1'b0;
      pend     <= 1'b0;
    end else begin
      pos_y <= POS_Y;
      if (tick) begin
        // A request arriving on the tick cycle itself waits for the next frame.
        pend <= bus.recenter;
        if (pend) begin
          pos_x    <= START_X;
          state    <= ST_IDLE;
          speed    <= SMIN;
          moving_q <= 1'b0;
        end else if (bus.enable) begin
          if (dir_l || dir_r) begin
            pos_x    <= dir_l ? left_x : right_x;
            state    <= tgt;
            speed    <= next_speed;
            moving_q <= 1'b1;
          end else begin
            state    <= ST_IDLE;
            speed    <= SMIN;
            moving_q <= 1'b0;
          end
        end
      end else if (bus.recenter) begin
        pend <= 1'b1;
      end
    end
  end

  assign bus.sprite_x   = pos_x;
  assign bus.sprite_y   = pos_y;
  assign bus.moving     = moving_q;
  assign bus.frame_tick = tick;

endmodule

// File: tb/tb_paddle_controller.sv
// Randomised and directed frame-level bench for paddle_controller against a
// behavioural position/speed model.
module tb_paddle_controller;

  logic clk;
  logic reset;

  paddle_controller_if bus();

  paddle_controller dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: position, speed, last direction (-1/0/+1), recenter pending
  int mx;
  int mspd;
  int mdir;
  bit mpend;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mx    = 288;
    mspd  = 2;
    mdir  = 0;
    mpend = 1'b0;
  endtask

  task automatic model_tick(input bit l, input bit r, input bit en);
    int d;
    int stp;
    if (mpend) begin
      mx    = 288;
      mspd  = 2;
      mdir  = 0;
      mpend = 1'b0;
    end else if (en) begin
      if (l != r) begin
        d = l ? -1 : 1;
        if (d == mdir) begin
          stp  = mspd;
          mspd = (mspd + 1 > 8) ? 8 : mspd + 1;
        end else begin
          stp  = 2;
          mspd = 3;
        end
        mx = mx + d * stp;
        if (mx < 0)   mx = 0;
        if (mx > 576) mx = 576;
        mdir = d;
      end else begin
        mdir = 0;
        mspd = 2;
      end
    end
  endtask

  task automatic run_frame(input bit l, input bit r, input bit en, input bit rc);
    int ticks;
    int tcyc;
    @(negedge clk);
    bus.btn_left  = l;
    bus.btn_right = r;
    bus.enable    = en;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rc && i == 6) begin
        bus.recenter = 1'b1;
        mpend = 1'b1;
      end else begin
        bus.recenter = 1'b0;
      end
      if (rc && i == 12) check("x_hold_after_recenter", int'(bus.sprite_x), mx);
    end
    bus.vsync = 1'b0;
    ticks = 0;
    tcyc  = 0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      if (bus.frame_tick) begin
        ticks++;
        tcyc = c;
      end
      if (c == 3) begin
        check("x_before_update", int'(bus.sprite_x), mx);
        model_tick(l, r, en);
      end
      if (c == 4) begin
        check("sprite_x", int'(bus.sprite_x), mx);
        check("sprite_y", int'(bus.sprite_y), 440);
        check("moving", int'(bus.moving), (mdir != 0) ? 1 : 0);
      end
    end
    check("tick_count", ticks, 1);
    check("tick_latency", tcyc, 3);
    @(negedge clk);
    bus.vsync = 1'b1;
  endtask

  initial begin
    int ticks;
    reset         = 1'b0;
    bus.vsync     = 1'b1;
    bus.enable    = 1'b1;
    bus.btn_left  = 1'b0;
    bus.btn_right = 1'b0;
    bus.recenter  = 1'b0;
    model_reset();

    #12;
    check("rst_x", int'(bus.sprite_x), 288);
    check("rst_y", int'(bus.sprite_y), 440);
    check("rst_moving", int'(bus.moving), 0);
    check("rst_tick", int'(bus.frame_tick), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    repeat (3) run_frame(1'b0, 1'b0, 1'b1, 1'b0);

    // Right ramp to the right clamp, release, then a fresh right press
    repeat (16) run_frame(1'b0, 1'b1, 1'b1, 1'b0);
    run_frame(1'b0, 1'b0, 1'b1, 1'b0);
    run_frame(1'b0, 1'b1, 1'b1, 1'b0);

    // Left all the way to the left clamp and beyond
    repeat (20) run_frame(1'b1, 1'b0, 1'b1, 1'b0);

    repeat (3) run_frame(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (6) run_frame(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) run_frame(1'b0, 1'b1, 1'b0, 1'b0);

    run_frame(1'b0, 1'b1, 1'b0, 1'b1);
    run_frame(1'b0, 1'b1, 1'b0, 1'b0);

    // Reset mid-frame while moving, released with vsync still low
    repeat (3) run_frame(1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    bus.vsync = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("midrst_x", int'(bus.sprite_x), 288);
    check("midrst_y", int'(bus.sprite_y), 440);
    check("midrst_moving", int'(bus.moving), 0);
    check("midrst_tick", int'(bus.frame_tick), 0);
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    ticks = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (bus.frame_tick) ticks++;
    end
    check("no_tick_after_release", ticks, 0);
    check("x_after_release", int'(bus.sprite_x), 288);
    @(negedge clk);
    bus.vsync = 1'b1;
    repeat (2) run_frame(1'b0, 1'b1, 1'b1, 1'b0);

    for (int f = 0; f < 40; f++) begin
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/paddle_controller.md
Name: paddle_controller

Overview:
Per-frame position generator for the player paddle (bar) sprite. It synchronises the two direction buttons and detects the start of vertical sync. Once per frame it updates the paddle X coordinate with accelerating speed, clamped to the visible area. Its sprite_x/sprite_y outputs drive the paddle sprite renderer directly; that renderer latches them on the falling edge of vsync.

Parameters:
SCREEN_W, 640, visible width in pixels
PADDLE_W, 64, paddle width in pixels (must match the renderer)
PADDLE_Y, 440, fixed paddle top row
SPEED_MIN, 2, pixels/frame on the first moving frame
SPEED_MAX, 8, speed ceiling in pixels/frame

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-low reset
vsync  in  1  raw vsync from the timing generator, active-low pulse
enable  in  1  game running; when 0, position is frozen
btn_left  in  1  asynchronous, active-high button
btn_right  in  1  asynchronous, active-high button
recenter  in  1  synchronous single-cycle request to return to centre
sprite_x  out  10  paddle left column
sprite_y  out  10  paddle top row, constant PADDLE_Y
moving  out  1  1 while state is MOVE_L or MOVE_R
frame_tick  out  1  one-cycle pulse per detected vsync falling edge

Behaviour:
- Derived constants:
  - MAX_X = SCREEN_W - PADDLE_W (576).
  - START_X = MAX_X/2 (288).
- Reset (reset=0, asynchronous):
  - sprite_x=START_X, sprite_y=PADDLE_Y.
  - speed=SPEED_MIN, state=IDLE, moving=0, frame_tick=0.
  - Synchroniser and edge flops cleared to the idle level; vsync flops are set to 1.
- Input synchronisation:
  - btn_left, btn_right and vsync each pass through a 2-flop synchroniser.
  - A third vsync flop provides edge detection.
  - frame_tick = 1 for exactly one cycle when the synced vsync goes 1->0.
  - Latency is 3 clk from the raw vsync falling edge.
- Recenter latch:
  - A recenter pulse sets a sticky pending flag.
  - The flag is consumed at the next frame_tick.
- All position, speed and state updates happen only in the cycle frame_tick=1.
  - Between ticks, outputs hold.
  - The renderer therefore sees a value that was stable for the whole previous frame; effective latency is one frame.
- State machine (IDLE, MOVE_L, MOVE_R), evaluated at frame_tick from the synced buttons L and R:
  - Priority 1, recenter pending: sprite_x=START_X, state=IDLE, speed=SPEED_MIN, flag cleared. Applies even when enable=0.
  - Priority 2, enable=0: nothing changes, and the state is held.
  - Otherwise, L&~R selects MOVE_L; R&~L selects MOVE_R.
  - Neither button, or both buttons: IDLE, speed=SPEED_MIN, no move.
  - Entering a moving state from IDLE or from the opposite direction: move by SPEED_MIN, then speed=SPEED_MIN+1.
  - Same direction as the previous frame: move by the current speed, then speed=min(speed+1, SPEED_MAX).
- Arithmetic (11-bit intermediate; no wrap permitted):
  - Left: if sprite_x < step then sprite_x=0, else sprite_x-step.
  - Right: if sprite_x+step > MAX_X then sprite_x=MAX_X, else sprite_x+step.
  - At a clamp the state stays MOVE_x and speed keeps ramping.
- moving is registered and reflects the state after the tick.
- sprite_y is constant PADDLE_Y (registered, reset value identical).
- Reset asserted mid-frame aborts any pending update. After release, the first update is at the next detected vsync falling edge; a vsync already low at release is not a new edge.

Decomposition:
- Shared game package holds SCREEN_W, SCREEN_H, PADDLE_W, PADDLE_H, PADDLE_Y and the state enum encoding. The renderer and ball logic share the same geometry.
- One natural sub-module, sync_edge: 2-flop synchroniser plus optional falling-edge pulse. It is instantiated for vsync (with edge) and for each button (level only).

Test Plan:
- Reset released, no buttons, 3 vsync pulses -> sprite_x=288, sprite_y=440, moving=0, one frame_tick per vsync, each 3 clk after the falling edge.
- Hold btn_right for 4 frames from 288 -> sprite_x 290, 293, 297, 302. Continue holding -> steps saturate at 8/frame.
- Force sprite_x=3 via left moves, then hold left with speed 4 -> next tick sprite_x=0. Further frames stay at 0, moving=1.
- Hold right until near the edge (x=572, speed 8) -> sprite_x=576 and stays there. Release -> IDLE, speed resets, next right press moves by 2.
- Both buttons held, and separately enable=0 with right held -> sprite_x unchanged across 3 frames.
- recenter pulse mid-frame while enable=0 at x=100 -> sprite_x=288 at the next frame_tick, never earlier.
- Reset asserted mid-frame while moving -> outputs return to 288/440/0 immediately. No update until a fresh vsync falling edge.
